// File: rtl/pifo_deq_ctrl_if.sv
// Output stream of the PIFO dequeue controller.
//   rank, meta : head-of-FIFO entry, qualified by valid
//   valid      : at least one entry is held
//   ready      : consumer accepts the head when valid && ready
// The master drives the entry and valid. The slave drives ready.
interface pifo_deq_ctrl_if #(
  parameter int RANK_WIDTH = 8,
  parameter int META_WIDTH = 8
);
  logic [RANK_WIDTH-1:0] rank;
  logic [META_WIDTH-1:0] meta;
  logic                  valid;
  logic                  ready;

  modport master (output rank, output meta, output valid, input ready);
  modport slave  (input rank, input meta, input valid, output ready);
endinterface

// File: rtl/pifo_deq_ctrl.sv
// Dequeue controller that sits directly downstream of the PIFO register stage.
// It issues single-cycle remove pulses whenever the PIFO's registered minimum
// is valid. It then skips the next cycle, because the PIFO's minimum is stale
// for one cycle after each remove. Each removed entry goes into a small
// first-word-fall-through FIFO, which drains onto a valid/ready stream.
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   pifo_rank_in      PIFO minimum rank (registered at the PIFO)
//   pifo_meta_in      PIFO minimum metadata
//   pifo_valid_in     PIFO minimum valid; low for one cycle after insert/remove
//   pifo_remove_out   remove pulse to the PIFO (combinational)
//   pause             suppresses new removes; the stream keeps draining
//   m                 output stream (rank/meta/valid out, ready in)
//   fifo_level        output FIFO occupancy, 0..2**L2_OUT_DEPTH
//   deq_count         removes issued since reset; wraps
module pifo_deq_ctrl #(
  parameter int RANK_WIDTH   = 8,
  parameter int META_WIDTH   = 8,
  parameter int L2_OUT_DEPTH = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RANK_WIDTH-1:0] pifo_rank_in,
  input  logic [META_WIDTH-1:0] pifo_meta_in,
  input  logic                  pifo_valid_in,
  output logic                  pifo_remove_out,
  input  logic                  pause,
  pifo_deq_ctrl_if.master       m,
  output logic [L2_OUT_DEPTH:0] fifo_level,
  output logic [CNT_WIDTH-1:0]  deq_count
);

  localparam int OUT_DEPTH = 1 << L2_OUT_DEPTH;
  localparam logic [L2_OUT_DEPTH:0] FULL_LEVEL = (L2_OUT_DEPTH + 1)'(OUT_DEPTH);

  typedef enum logic {ARMED, HOLD} state_t;

  typedef struct packed {
    logic [RANK_WIDTH-1:0] rank;
    logic [META_WIDTH-1:0] meta;
  } entry_t;

  state_t                  state;
  entry_t                  mem [OUT_DEPTH];
  logic [L2_OUT_DEPTH-1:0] wr_ptr;
  logic [L2_OUT_DEPTH-1:0] rd_ptr;
  entry_t                  head;
  logic                    push;
  logic                    pop;

  // Removal never looks at m.ready. A full FIFO blocks a remove even when the
  // head is popped in the same cycle, which keeps ready off this path.
  assign pifo_remove_out = (state == ARMED) && pifo_valid_in && !pause &&
                           (fifo_level < FULL_LEVEL) && !rst;
  assign push = pifo_remove_out;
  assign pop  = m.valid && m.ready;

  assign head    = mem[rd_ptr];
  assign m.rank  = head.rank;
  assign m.meta  = head.meta;
  assign m.valid = (fifo_level != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARMED;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      deq_count  <= '0;
    end else begin
      unique case (state)
        ARMED:   if (push) state <= HOLD;
        HOLD:    state <= ARMED;
        default: state <= ARMED;
      endcase

      // Pointers wrap modulo OUT_DEPTH through their natural width.
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        deq_count <= deq_count + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (!push && pop) fifo_level <= fifo_level - 1'b1;
    end
  end

  // NOTE: the storage array has no reset. Its contents are only observable
  // while fifo_level is non-zero, and resetting it would add no value.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rank: pifo_rank_in, meta: pifo_meta_in};
  end

endmodule

// File: tb/tb_pifo_deq_ctrl.sv
// Self-checking bench for pifo_deq_ctrl (L2_OUT_DEPTH=1, CNT_WIDTH=4).
// A small PIFO model serves entries. It blanks its valid for the cycle after
// each remove. A reference model predicts remove, level and count each cycle,
// and a scoreboard queue checks the stream contents and order.
module tb_pifo_deq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pifo_rank_in;
  logic [7:0] pifo_meta_in;
  logic       pifo_valid_in;
  logic       pifo_remove_out;
  logic       pause;
  logic [1:0] fifo_level;
  logic [3:0] deq_count;

  pifo_deq_ctrl_if #(.RANK_WIDTH(8), .META_WIDTH(8)) m_if ();

  pifo_deq_ctrl #(
    .RANK_WIDTH(8), .META_WIDTH(8), .L2_OUT_DEPTH(1), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .pifo_rank_in(pifo_rank_in), .pifo_meta_in(pifo_meta_in),
    .pifo_valid_in(pifo_valid_in), .pifo_remove_out(pifo_remove_out),
    .pause(pause), .m(m_if),
    .fifo_level(fifo_level), .deq_count(deq_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [15:0] pifo_q[$];     // entries the PIFO model will serve
  logic [15:0] exp_q[$];      // scoreboard: entries expected on the stream
  logic [7:0]  out_log[$];    // ranks actually accepted from the stream
  int          rem_cycles[$]; // cycles in which a remove was expected
  logic        pifo_blank = 1'b0;
  logic        blank_en   = 1'b1;
  logic        mdl_hold   = 1'b0;
  int          mdl_level  = 0;
  logic [3:0]  mdl_count  = '0;

  // One clock cycle: drive at posedge+1, sample at the falling edge.
  task automatic run_cycle();
    logic exp_rem;
    logic exp_pop;
    pifo_valid_in = !pifo_blank && (pifo_q.size() != 0);
    if (pifo_valid_in) {pifo_rank_in, pifo_meta_in} = pifo_q[0];
    else               {pifo_rank_in, pifo_meta_in} = 16'($urandom);
    #4;
    exp_rem = !rst && !mdl_hold && pifo_valid_in && !pause && (mdl_level < 2);
    exp_pop = (mdl_level != 0) && m_if.ready;

    n_checks++;
    if (pifo_remove_out !== exp_rem)
      $display("FAIL remove cyc %0d: got %b expected %b", cyc, pifo_remove_out, exp_rem);
    else n_pass++;
    n_checks++;
    if (m_if.valid !== (mdl_level != 0))
      $display("FAIL m_valid cyc %0d: got %b expected %b", cyc, m_if.valid, mdl_level != 0);
    else n_pass++;
    n_checks++;
    if (fifo_level !== 2'(mdl_level))
      $display("FAIL fifo_level cyc %0d: got %0d expected %0d", cyc, fifo_level, mdl_level);
    else n_pass++;
    n_checks++;
    if (deq_count !== mdl_count)
      $display("FAIL deq_count cyc %0d: got %0d expected %0d", cyc, deq_count, mdl_count);
    else n_pass++;
    if (mdl_level != 0) begin
      n_checks++;
      if ({m_if.rank, m_if.meta} !== exp_q[0])
        $display("FAIL head cyc %0d: got %h expected %h", cyc, {m_if.rank, m_if.meta}, exp_q[0]);
      else n_pass++;
    end
    if (exp_pop) out_log.push_back(m_if.rank);

    if (rst) begin
      mdl_level = 0;
      mdl_hold  = 1'b0;
      mdl_count = '0;
      exp_q.delete();
    end else begin
      if (exp_pop) void'(exp_q.pop_front());
      if (exp_rem) begin
        exp_q.push_back(pifo_q.pop_front());
        mdl_count++;
        rem_cycles.push_back(cyc);
      end
      mdl_level = mdl_level + int'(exp_rem) - int'(exp_pop);
      mdl_hold  = exp_rem;
    end
    pifo_blank = blank_en && exp_rem;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic test_reset();
    int n0;
    rst = 1'b1;
    pifo_q.push_back(16'h33C4);
    run_n(2);
    n0 = rem_cycles.size();
    rst = 1'b0;
    run_cycle();
    n_checks++;
    if (n0 != 0 || rem_cycles.size() != 1 || rem_cycles[0] != cyc - 1)
      $display("FAIL reset_first_remove: got %0d removes expected 1 in cycle after reset", rem_cycles.size());
    else n_pass++;
    m_if.ready = 1'b1;
    run_n(3);
  endtask

  task automatic test_single();
    int n0;
    int t0;
    blank_en = 1'b0;  // keep PIFO valid high at t+1 to prove HOLD gating
    pifo_q.push_back(16'h05A1);
    pifo_q.push_back(16'h09B2);
    m_if.ready = 1'b1;
    out_log.delete();
    n0 = rem_cycles.size();
    t0 = cyc;
    run_n(2);
    n_checks++;
    if (rem_cycles.size() - n0 != 1 || rem_cycles[n0] != t0)
      $display("FAIL single_remove_timing: got %0d removes expected 1 at cycle %0d", rem_cycles.size() - n0, t0);
    else n_pass++;
    run_n(4);
    n_checks++;
    if (out_log.size() != 2 || out_log[0] != 8'h05 || out_log[1] != 8'h09)
      $display("FAIL single_stream: got %0d entries expected ranks 05,09", out_log.size());
    else n_pass++;
    blank_en = 1'b1;
  endtask

  task automatic test_sustained();
    int n0;
    int t0;
    out_log.delete();
    for (int i = 1; i <= 4; i++) pifo_q.push_back({8'(i), 8'(8'h10 + i)});
    m_if.ready = 1'b1;
    n0 = rem_cycles.size();
    t0 = cyc;
    run_n(10);
    n_checks++;
    if (rem_cycles.size() - n0 != 4)
      $display("FAIL sustained_count: got %0d expected 4", rem_cycles.size() - n0);
    else n_pass++;
    for (int i = 0; i < 4 && n0 + i < rem_cycles.size(); i++) begin
      n_checks++;
      if (rem_cycles[n0 + i] != t0 + 2 * i)
        $display("FAIL sustained_rate[%0d]: got cycle %0d expected %0d", i, rem_cycles[n0 + i], t0 + 2 * i);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= out_log.size() || out_log[i] != 8'(i + 1))
        $display("FAIL sustained_order[%0d]: got %0d entries expected rank %0d", i, out_log.size(), i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int n0;
    m_if.ready = 1'b0;
    for (int i = 0; i < 6; i++) pifo_q.push_back({8'(8'h40 + i), 8'hEE});
    n0 = rem_cycles.size();
    run_n(8);
    n_checks++;
    if (rem_cycles.size() - n0 != 2 || fifo_level !== 2'd2)
      $display("FAIL backpressure_full: got %0d removes level %0d expected 2 removes level 2", rem_cycles.size() - n0, fifo_level);
    else n_pass++;
    m_if.ready = 1'b1;
    run_cycle();  // pop while full; the remove stays blocked
    m_if.ready = 1'b0;
    run_cycle();  // level 1 now, so the remove resumes
    n_checks++;
    if (rem_cycles.size() - n0 != 3 || rem_cycles[$] != cyc - 1)
      $display("FAIL backpressure_resume: got %0d removes expected 3", rem_cycles.size() - n0);
    else n_pass++;
    pifo_q.delete();
    m_if.ready = 1'b1;
    run_n(4);
  endtask

  task automatic test_pause_wrap();
    int  n0;
    int  k;
    bit  seen15;
    bit  seen16;
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    pause = 1'b1;
    m_if.ready = 1'b1;
    for (int i = 0; i < 16; i++) pifo_q.push_back({8'(8'h80 + i), 8'(i)});
    n0 = rem_cycles.size();
    run_n(10);
    n_checks++;
    if (rem_cycles.size() != n0)
      $display("FAIL pause_blocks: got %0d removes expected 0", rem_cycles.size() - n0);
    else n_pass++;
    pause = 1'b0;
    seen15 = 1'b0;
    seen16 = 1'b0;
    for (int i = 0; i < 60 && !seen16; i++) begin
      run_cycle();
      k = rem_cycles.size() - n0;
      if (k == 15 && !seen15) begin
        seen15 = 1'b1;
        n_checks++;
        if (deq_count !== 4'd15) $display("FAIL count_15: got %0d expected 15", deq_count);
        else n_pass++;
      end
      if (k == 16) begin
        seen16 = 1'b1;
        n_checks++;
        if (deq_count !== 4'd0) $display("FAIL count_wrap: got %0d expected 0", deq_count);
        else n_pass++;
      end
    end
    if (!seen16) begin
      n_checks++;
      $display("FAIL pause_wrap_timeout: got %0d removes expected 16", rem_cycles.size() - n0);
    end
    run_n(3);
  endtask

  task automatic test_reset_mid_hold();
    int n0;
    m_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) pifo_q.push_back({8'(8'hC0 + i), 8'h5A});
    run_n(3);  // remove, hold, remove: now in HOLD with a full FIFO
    n_checks++;
    if (fifo_level !== 2'd2) $display("FAIL midhold_setup: got level %0d expected 2", fifo_level);
    else n_pass++;
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    out_log.delete();
    n_checks++;
    if (fifo_level !== 2'd0 || m_if.valid !== 1'b0)
      $display("FAIL midhold_reset: got level %0d valid %b expected 0 0", fifo_level, m_if.valid);
    else n_pass++;
    pifo_q.delete();
    pifo_q.push_back(16'h7788);
    m_if.ready = 1'b1;
    n0 = rem_cycles.size();
    run_cycle();  // FSM must be ARMED right after reset
    n_checks++;
    if (rem_cycles.size() - n0 != 1)
      $display("FAIL midhold_armed: got %0d removes expected 1", rem_cycles.size() - n0);
    else n_pass++;
    run_n(3);
    n_checks++;
    if (out_log.size() != 1 || out_log[0] != 8'h77)
      $display("FAIL midhold_no_stale: got %0d entries expected only rank 77", out_log.size());
    else n_pass++;
  endtask

  initial begin
    rst           = 1'b1;
    pause         = 1'b0;
    m_if.ready    = 1'b0;
    pifo_valid_in = 1'b0;
    pifo_rank_in  = '0;
    pifo_meta_in  = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_sustained();
    test_backpressure();
    test_pause_wrap();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
